ppbuffer_rd_ctrl: RTL

//  Consumer-side read controller for the ping-pong bit buffer (PPBuffer) in the WiMAX TX chain.

---
 rtl/wimax_pkg.sv | 25 ++
 rtl/ppbuffer_rd_addr_gen.sv | 98 +++++++++
 rtl/ppbuffer_rd_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/wimax_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wimax_pkg
//  Brief    : Shared constants and types for the WiMAX TX PPBuffer read side.
//  Revision : 1.0
// ============================================================================
package wimax_pkg;

  localparam int N_CBPS_QPSK  = 192;
  localparam int WIMAX_D_COLS = 16;
  localparam int PPB_ADDR_W   = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

  typedef struct packed {
    logic data;
    logic last;
  } fifo_entry_t;

endpackage : wimax_pkg
`default_nettype wire

// File: rtl/ppbuffer_rd_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : ppbuffer_rd_addr_gen
//  Brief    : Bit index counter with incremental block-interleaver read address.
//  Revision : 1.0
// ============================================================================
module ppbuffer_rd_addr_gen
  import wimax_pkg::*;
#(
  parameter int N_CBPS     = N_CBPS_QPSK,
  parameter int D_COLS     = WIMAX_D_COLS,
  parameter int INTERLEAVE = 1,
  parameter int ADDR_W     = PPB_ADDR_W
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              step_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_k_o
);

  localparam int                ROWS     = N_CBPS / D_COLS;
  localparam int                COL_W    = (D_COLS > 1) ? $clog2(D_COLS) : 1;
  localparam logic [ADDR_W-1:0] K_LAST   = ADDR_W'(N_CBPS - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(ROWS);
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(D_COLS - 1);

  logic [ADDR_W-1:0] k_q, k_d;
  logic              restart;

  assign last_k_o = (k_q == K_LAST);
  // Stepping past the last index wraps so a back-to-back block needs no bubble.
  assign restart  = start_i || (step_i && last_k_o);

  always_comb begin
    k_d = k_q;
    if (restart) begin
      k_d = '0;
    end else if (step_i) begin
      k_d = k_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      k_q <= '0;
    end else begin
      k_q <= k_d;
    end
  end

  generate
    if (INTERLEAVE != 0) begin : g_interleave
      logic [COL_W-1:0]  col_q, col_d;
      logic [ADDR_W-1:0] row_q, row_d;
      logic [ADDR_W-1:0] addr_q, addr_d;

      always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        addr_d = addr_q;
        if (restart) begin
          col_d  = '0;
          row_d  = '0;
          addr_d = '0;
        end else if (step_i) begin
          if (col_q == COL_LAST) begin
            col_d  = '0;
            row_d  = row_q + ADDR_W'(1);
            addr_d = row_q + ADDR_W'(1);
          end else begin
            col_d  = col_q + COL_W'(1);
            addr_d = addr_q + ROW_STEP;
          end
        end
      end

      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          col_q  <= '0;
          row_q  <= '0;
          addr_q <= '0;
        end else begin
          col_q  <= col_d;
          row_q  <= row_d;
          addr_q <= addr_d;
        end
      end

      assign addr_o = addr_q;
    end else begin : g_linear
      assign addr_o = k_q;
    end
  endgenerate

endmodule : ppbuffer_rd_addr_gen
`default_nettype wire

// File: rtl/ppbuffer_rd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ppbuffer_rd_ctrl
//  Brief    : PPBuffer consumer: block sequencing, read issue, 2-deep output FIFO.
//  Revision : 1.0
// ============================================================================
module ppbuffer_rd_ctrl
  import wimax_pkg::*;
#(
  parameter int N_CBPS     = N_CBPS_QPSK,
  parameter int D_COLS     = WIMAX_D_COLS,
  parameter int INTERLEAVE = 1,
  parameter int ADDR_W     = PPB_ADDR_W
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              blk_ready_i,
  input  logic              q_i,
  output logic [ADDR_W-1:0] rdaddress_o,
  output logic              dout_o,
  output logic              dout_valid_o,
  input  logic              dout_ready_i,
  output logic              blk_done_o,
  output logic              overflow_o
);

  rd_state_t         state_q, state_d;
  logic              pending_q, pending_d;
  logic              overflow_q, overflow_d;
  logic              inflight_q, inflight_last_q;
  logic [ADDR_W-1:0] rdaddr_hold_q;
  logic [ADDR_W-1:0] gen_addr;
  logic              gen_last;
  logic              issue, start;
  logic              push, pop, can_issue;
  fifo_entry_t       fifo_q [2];
  logic              rd_ptr_q, wr_ptr_q;
  logic [1:0]        count_q;

  ppbuffer_rd_addr_gen #(
    .N_CBPS     (N_CBPS),
    .D_COLS     (D_COLS),
    .INTERLEAVE (INTERLEAVE),
    .ADDR_W     (ADDR_W)
  ) u_addr_gen (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .start_i  (start),
    .step_i   (issue),
    .addr_o   (gen_addr),
    .last_k_o (gen_last)
  );

  assign push = inflight_q;
  assign pop  = (count_q != 2'd0) && dout_ready_i;
  // A pop in this cycle frees a slot in time for a new issue, sustaining 1 bit/clk.
  assign can_issue = ({1'b0, count_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    overflow_d = overflow_q;
    start      = 1'b0;
    issue      = 1'b0;

    case (state_q)
      IDLE: begin
        if (pending_q) begin
          start   = 1'b1;
          state_d = READ;
        end
      end
      READ: begin
        if (can_issue) begin
          issue = 1'b1;
          if (gen_last) begin
            if (pending_q) begin
              start   = 1'b1;
              state_d = READ;
            end else begin
              state_d = DRAIN;
            end
          end
        end
      end
      DRAIN: begin
        if ((count_q == 2'd0) && !inflight_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      pending_d = 1'b0;
    end
    if (blk_ready_i) begin
      if (pending_q && !start) begin
        overflow_d = 1'b1;
      end
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      pending_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rdaddr_hold_q   <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      fifo_q[0]       <= '0;
      fifo_q[1]       <= '0;
      rd_ptr_q        <= 1'b0;
      wr_ptr_q        <= 1'b0;
      count_q         <= 2'd0;
    end else begin
      if (issue) begin
        rdaddr_hold_q <= gen_addr;
      end
      inflight_q      <= issue;
      inflight_last_q <= issue && gen_last;
      if (push) begin
        fifo_q[wr_ptr_q] <= '{data: q_i, last: inflight_last_q};
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign rdaddress_o  = issue ? gen_addr : rdaddr_hold_q;
  assign dout_o       = fifo_q[rd_ptr_q].data;
  assign dout_valid_o = (count_q != 2'd0);
  assign blk_done_o   = pop && fifo_q[rd_ptr_q].last;
  assign overflow_o   = overflow_q;

endmodule : ppbuffer_rd_ctrl
`default_nettype wire
